// File: rtl/cpu_pkg.sv
// Shared opcode, ALU select, FSM state and control-word definitions for the
// 8-bit CPU control unit.
package cpu_pkg;

  localparam int FIELD_W = 4;
  localparam int REG_W   = 3;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_MULT = 4'h4;
  localparam logic [3:0] OP_DISP = 4'h5;
  localparam logic [3:0] OP_STUR = 4'h6;
  localparam logic [3:0] OP_LDUR = 4'h7;
  localparam logic [3:0] OP_HALT = 4'h9;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_MULT = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_OR   = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_WB     = 3'd4;
  localparam state_t ST_DISP   = 3'd5;
  localparam state_t ST_HALT   = 3'd6;

  // Instruction class; exactly one is_* bit is set when legal is high.
  typedef struct packed {
    logic legal;
    logic is_alu;
    logic is_stur;
    logic is_ldur;
    logic is_disp;
    logic is_halt;
  } kind_t;

  typedef struct packed {
    kind_t              kind;
    logic [1:0]         alu_sel;
    logic               b_imm;
    logic               a_zero;
    logic [REG_W-1:0]   ra;
    logic [REG_W-1:0]   rb;
    logic [REG_W-1:0]   wa;
    logic [FIELD_W-1:0] maddr;
  } ctrl_word_t;

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decode: legality check and per-opcode control word.
// Illegal instructions produce an all-zero control word so selects stay quiet.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output ctrl_word_t  cw
);

  logic [3:0] op, rd, rn, rm;

  assign op = ir[15:12];
  assign rd = ir[11:8];
  assign rn = ir[7:4];
  assign rm = ir[3:0];

  // Per-opcode control word; only fields used as register indices are checked.
  always_comb begin
    cw = '0;
    case (op)
      OP_ADD, OP_AND, OP_OR, OP_MULT: begin
        cw.kind.is_alu = 1'b1;
        cw.kind.legal  = !(rd[3] | rn[3] | rm[3]);
        cw.alu_sel     = (op == OP_MULT) ? ALU_MULT :
                         (op == OP_AND)  ? ALU_AND  :
                         (op == OP_OR)   ? ALU_OR   : ALU_ADD;
        cw.ra          = rn[2:0];
        cw.rb          = rm[2:0];
        cw.wa          = rd[2:0];
      end
      OP_ADDI: begin
        cw.kind.is_alu = 1'b1;
        cw.kind.legal  = !(rd[3] | rn[3]);
        cw.alu_sel     = ALU_ADD;
        cw.b_imm       = 1'b1;
        cw.ra          = rn[2:0];
        cw.wa          = rd[2:0];
      end
      OP_DISP: begin
        cw.kind.is_disp = 1'b1;
        cw.kind.legal   = 1'b1;
      end
      OP_STUR: begin
        // Store passes Rx[Rn] through the ALU as 0 + B.
        cw.kind.is_stur = 1'b1;
        cw.kind.legal   = !rn[3];
        cw.alu_sel      = ALU_ADD;
        cw.a_zero       = 1'b1;
        cw.rb           = rn[2:0];
        cw.maddr        = rd;
      end
      OP_LDUR: begin
        cw.kind.is_ldur = 1'b1;
        cw.kind.legal   = !rn[3];
        cw.wa           = rn[2:0];
        cw.maddr        = rd;
      end
      OP_HALT: begin
        cw.kind.is_halt = 1'b1;
        cw.kind.legal   = 1'b1;
      end
      default: cw = '0;
    endcase
    if (!cw.kind.legal) cw = '0;
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit: fetch, decode and per-instruction sequencing of the
// ALU, bus mux, register file and data memory. All outputs are registered from
// the next state and next instruction word so they change only on clk.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W  = 4,
  parameter int RET_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [15:0]      imem_rd,
  output logic [PC_W-1:0]  pc,
  output logic [15:0]      ir,
  output logic [1:0]       alu_sel,
  output logic             alu_mux,
  output logic             b_imm,
  output logic             a_zero,
  output logic [2:0]       rf_ra,
  output logic [2:0]       rf_rb,
  output logic [2:0]       rf_wa,
  output logic             rf_we,
  output logic [3:0]       dmem_addr,
  output logic             dmem_we,
  output logic             dmem_oe,
  output logic             disp_pulse,
  output logic             illegal,
  output logic             halted,
  output logic [RET_W-1:0] retired
);

  state_t     state, nxt_state;
  logic [15:0] nxt_ir;
  ctrl_word_t cw_nxt;
  kind_t      kind_q;
  logic       retire;

  cpu_decode u_decode (
    .ir (nxt_ir),
    .cw (cw_nxt)
  );

  // Next state and next instruction word.
  always_comb begin
    nxt_state = state;
    nxt_ir    = ir;
    case (state)
      ST_FETCH: begin
        if (run) begin
          nxt_ir    = imem_rd;
          nxt_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!kind_q.legal)                        nxt_state = ST_FETCH;
        else if (kind_q.is_alu || kind_q.is_stur) nxt_state = ST_EXEC;
        else if (kind_q.is_ldur)                  nxt_state = ST_MEM;
        else if (kind_q.is_disp)                  nxt_state = ST_DISP;
        else                                      nxt_state = ST_HALT;
      end
      ST_EXEC:  nxt_state = kind_q.is_alu ? ST_WB : ST_MEM;
      ST_MEM:   nxt_state = kind_q.is_stur ? ST_FETCH : ST_WB;
      ST_WB:    nxt_state = ST_FETCH;
      ST_DISP:  nxt_state = ST_FETCH;
      ST_HALT:  nxt_state = ST_HALT;
      default:  nxt_state = ST_FETCH;
    endcase
  end

  // Last cycle of a legal instruction; HALT counts as it enters its state.
  assign retire = (state == ST_WB) || (state == ST_DISP) ||
                  (state == ST_MEM && kind_q.is_stur) ||
                  (state == ST_DECODE && kind_q.legal && kind_q.is_halt);

  // State, counters and Moore outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_FETCH;
      ir         <= '0;
      kind_q     <= '0;
      pc         <= '0;
      retired    <= '0;
      alu_sel    <= '0;
      b_imm      <= 1'b0;
      a_zero     <= 1'b0;
      rf_ra      <= '0;
      rf_rb      <= '0;
      rf_wa      <= '0;
      dmem_addr  <= '0;
      alu_mux    <= 1'b0;
      rf_we      <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_oe    <= 1'b0;
      disp_pulse <= 1'b0;
      illegal    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state   <= nxt_state;
      ir      <= nxt_ir;
      kind_q  <= cw_nxt.kind;
      if (state == ST_FETCH && run) pc <= pc + PC_W'(1);
      if (retire) retired <= retired + RET_W'(1);
      alu_sel    <= cw_nxt.alu_sel;
      b_imm      <= cw_nxt.b_imm;
      a_zero     <= cw_nxt.a_zero;
      rf_ra      <= cw_nxt.ra;
      rf_rb      <= cw_nxt.rb;
      rf_wa      <= cw_nxt.wa;
      dmem_addr  <= cw_nxt.maddr;
      alu_mux    <= (nxt_state == ST_EXEC) ||
                    (nxt_state == ST_MEM && cw_nxt.kind.is_stur) ||
                    (nxt_state == ST_WB && cw_nxt.kind.is_alu);
      rf_we      <= (nxt_state == ST_WB);
      dmem_we    <= (nxt_state == ST_MEM && cw_nxt.kind.is_stur);
      dmem_oe    <= (nxt_state == ST_MEM || nxt_state == ST_WB) && cw_nxt.kind.is_ldur;
      disp_pulse <= (nxt_state == ST_DISP);
      illegal    <= (nxt_state == ST_DECODE) && !cw_nxt.kind.legal;
      halted     <= (nxt_state == ST_HALT);
    end
  end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle control unit for the 8-bit CPU. Fetches 16-bit instructions from the instruction memory and decodes `opcode/Rd/Rn/Rm`. Sequences the ALU, datapath bus mux, register file and data memory through a per-instruction state machine. Replaces free-running testbench-style sequencing with a reset-able, stallable FSM that the top-level CPU instantiates beside `alu`, `datapath`, `dmem` and `imem`.

## Interface
Parameters:
- `PC_W`, 4, program counter and `imem` address width.
- `RET_W`, 8, retired-instruction counter width.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  fetch enable; sampled only in FETCH.
- `imem_rd`  in  16  instruction word at `pc`; combinational from `imem`.
- `pc`  out  PC_W  instruction address.
- `ir`  out  16  latched instruction.
- `alu_sel`  out  2  ALU op: 00 add, 01 mult, 10 and, 11 or.
- `alu_mux`  out  1  datapath drives ALU result onto bus.
- `b_imm`  out  1  ALU B operand = zero-extended `ir[3:0]` instead of `Rx[Rm]`.
- `a_zero`  out  1  ALU A operand forced to 0.
- `rf_ra`, `rf_rb`  out  3  register read indices (A, B).
- `rf_wa`  out  3  register write index.
- `rf_we`  out  1  register write strobe; data taken from bus.
- `dmem_addr`  out  4  data memory address.
- `dmem_we`, `dmem_oe`  out  1  data memory write / output enable.
- `disp_pulse`  out  1  one-cycle register-dump request.
- `illegal`  out  1  one-cycle pulse on undefined opcode or bad register index.
- `halted`  out  1  high once HALT executes.
- `retired`  out  RET_W  count of completed instructions; wraps.

## Operation
- Decode: `op=ir[15:12]`, `Rd=ir[11:8]`, `Rn=ir[7:4]`, `Rm=ir[3:0]`.
- Opcodes:
  - 0 ADD, 2 AND, 3 OR, 4 MULT: `Rx[Rd] = Rx[Rn] op Rx[Rm]`.
  - 1 ADDI: `Rx[Rd] = Rx[Rn] + Rm`.
  - 5 DISPLAY.
  - 6 STUR: `mem[Rd] = Rx[Rn]`, via ALU with `a_zero`.
  - 7 LDUR: `Rx[Rn] = mem[Rd]`.
  - 9 HALT.
  - All others are illegal.
- Register operands index an 8-entry file. Any register-role field (Rd for ALU ops, Rn, or Rm for non-ADDI) with bit 3 set is illegal.
  - Memory-address fields (Rd of STUR/LDUR) use all 4 bits.
- Illegal instruction: pulse `illegal` in DECODE, no side effects, return to FETCH, not counted in `retired`.
- States: FETCH, DECODE, EXEC, MEM, WB, DISP, HALT.
  - FETCH: if `run`, `ir<=imem_rd`, `pc<=pc+1` (wraps 15→0), go to DECODE; else hold.
  - DECODE: drive `rf_ra/rf_rb/b_imm/a_zero`. Next state: ALU ops and STUR → EXEC; LDUR → MEM; DISPLAY → DISP; HALT → HALT; illegal → FETCH.
  - EXEC: `alu_mux=1`, `alu_sel` valid. ALU ops → WB; STUR → MEM.
  - MEM:
    - STUR: `alu_mux=1`, `dmem_we=1`, `dmem_addr=Rd`; then FETCH.
    - LDUR: `dmem_oe=1`, `dmem_addr=Rd`; then WB.
  - WB:
    - ALU ops: `alu_mux=1`, `rf_we=1`, `rf_wa=Rd[2:0]`.
    - LDUR: `dmem_oe=1`, `rf_we=1`, `rf_wa=Rn[2:0]`.
    - Then FETCH.
  - DISP: `disp_pulse=1`; then FETCH.
  - HALT: `halted=1`, all strobes 0; left only by `rst`.
- `retired` increments on the last cycle of every legal instruction, including HALT's entry.
- Operand/select outputs hold stable from DECODE through the instruction's last state. Strobes are 0 outside the states listed above.

## Timing
- Reset values:
  - state FETCH, `pc=0`, `ir=0`, `retired=0`, `alu_sel=00`, `rf_ra/rf_rb/rf_wa=0`, `dmem_addr=0`.
  - All strobes, `halted` and `illegal` = 0.
- Cycles per instruction, FETCH inclusive:
  - ALU ops: 4 (F, D, E, W).
  - STUR: 4 (F, D, E, M).
  - LDUR: 4 (F, D, M, W).
  - DISPLAY: 3.
  - illegal: 2.
- `bus` must never be driven by both `alu_mux` and `dmem_oe` in the same cycle.
- `rst` mid-instruction: immediate return to reset values; a pending `rf_we`/`dmem_we` is dropped.
- `run` deasserted mid-instruction: the instruction completes; the stall takes effect at the next FETCH.
- Outputs are Moore (state + `ir`), glitch-free relative to `clk`.

## Structure
- Package `cpu_pkg`: opcode localparams (`OP_ADD`…`OP_HALT`), `alu_sel` encodings, state enum, instruction field slice widths.
- One sub-module, `cpu_decode`: combinational opcode/field legality check and per-opcode control word. The FSM and counters stay in `cpu_ctrl`.

## Test plan
- Reset then `run=1` with `imem[0]=16'h1105` (ADDI R1=R0+5): `rf_we` in cycle 4 with `rf_wa=1`, `b_imm=1`, `alu_sel=00`; `pc=1`; `retired=1`.
- ADD `16'h0312` then MULT `16'h4433`: each takes 4 cycles, `alu_sel` 00 then 01, `rf_wa` 3 then 4.
- STUR `16'h6A20` then LDUR `16'h7A50`:
  - STUR: `dmem_we` in cycle 4, `dmem_addr=10`, `a_zero=1`.
  - LDUR: `dmem_oe` in cycles 3–4, `rf_we` in cycle 4 with `rf_wa=5`.
  - `alu_mux` and `dmem_oe` are never simultaneously high.
- Illegal cases:
  - Opcode `4'hC` pulses `illegal` in cycle 2, with no `rf_we`/`dmem_we` and `retired` unchanged.
  - ADD with `Rm=8` behaves the same way.
- `run=0` at FETCH for 5 cycles: `pc` and `ir` hold. Program of 16 NOP-equivalent ADDIs: `pc` wraps 15→0.
- HALT `16'h9000`: `halted=1` permanently, all strobes 0. `rst` asserted mid-ALU-op (during EXEC): all outputs go to reset values asynchronously, and no write occurs.
